// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul front end.
// Imported by the loader and by the matmul core.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD,
        DONE
    } loader_state_t;

    function automatic int idx_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/matmul_loader.sv
// Stream-to-matrix loader: packs A then B, holds them
// for the core latency, then offers C downstream.
module matmul_loader
    import matmul_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [N*N*WIDTH-1:0]    A_flat,
    output logic [N*N*WIDTH-1:0]    B_flat,
    output logic                    mat_valid,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic                    err
);

    localparam int NN = N * N;
    localparam int CW = $clog2(NN);
    localparam int LW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATENCY - 1);

    loader_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [LW-1:0] lat_cnt, lat_nx;
    logic          err_nx;
    logic          wr_a, wr_b;
    logic          accept;
    logic          run;

    // Handshake/status flags come from registers only; run
    // keeps s_ready low for every cycle spent in reset.
    assign s_ready   = run && (state == LOAD_A || state == LOAD_B);
    assign mat_valid = (state == HOLD) || (state == DONE);
    assign c_valid   = (state == DONE);
    assign accept    = s_valid && s_ready;

    // Next-state, counter and write-enable decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lat_nx   = lat_cnt;
        err_nx   = 1'b0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        unique case (state)
            LOAD_A: begin
                if (accept) begin
                    if (s_last) begin
                        err_nx = 1'b1;
                        cnt_nx = '0;
                    end else if (cnt == CNT_LAST) begin
                        wr_a     = 1'b1;
                        cnt_nx   = '0;
                        state_nx = LOAD_B;
                    end else begin
                        wr_a   = 1'b1;
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (cnt == CNT_LAST) begin
                        wr_b     = 1'b1;
                        cnt_nx   = '0;
                        err_nx   = !s_last;
                        state_nx = HOLD;
                    end else if (s_last) begin
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = LOAD_A;
                    end else begin
                        wr_b   = 1'b1;
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                lat_nx = lat_cnt + 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (c_ready) begin
                    lat_nx   = '0;
                    state_nx = LOAD_A;
                end
            end
            default: state_nx = LOAD_A;
        endcase
    end

    // State, counters, error pulse and operand packing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= LOAD_A;
            cnt     <= '0;
            lat_cnt <= '0;
            err     <= 1'b0;
            run     <= 1'b0;
            A_flat  <= '0;
            B_flat  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lat_cnt <= lat_nx;
            err     <= err_nx;
            run     <= 1'b1;
            for (int k = 0; k < NN; k++) begin
                if (cnt == k[CW-1:0]) begin
                    if (wr_a)
                        A_flat[idx_lsb(k, WIDTH) +: WIDTH] <= s_data;
                    if (wr_b)
                        B_flat[idx_lsb(k, WIDTH) +: WIDTH] <= s_data;
                end
            end
        end
    end

endmodule
